// File: rtl/vlsu_req_arbiter.sv
// vlsu_req_arbiter: shares the single fragmenter request port between the load and store requesters.
// Optional starvation guard enabled by defining RIVA_REQ_ARB_STARVE_EN.
package vlsu_req_arbiter_pkg;
    typedef struct packed {
        logic        isLoad;
        logic [31:0] addr;
        logic [7:0]  len;
    } vlsu_req_default_t;
endpackage

module vlsu_req_arbiter #(
    parameter type         vlsu_req_t     = vlsu_req_arbiter_pkg::vlsu_req_default_t,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned StarveLimit    = 8,
    localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ld_req_valid_i,
    output logic            ld_req_ready_o,
    input  vlsu_req_t       ld_req_i,
    input  logic            st_req_valid_i,
    output logic            st_req_ready_o,
    input  vlsu_req_t       st_req_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output vlsu_req_t       req_o,
    input  logic            req_done_i,
    output logic            dir_o,
    output logic [CntW-1:0] outstanding_o,
    output logic            err_o,
    output logic [1:0]      state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_e;

    state_e          state_r;
    logic            dir_r;
    logic            last_ld_r;
    logic [CntW-1:0] count_r;
    logic            err_r;

    logic pick_ld;
    logic grant_ok;
    logic sel_valid;
    logic hs;
    logic hold;
    logic dir_valid;
    logic other_valid;
    logic starve;

    // In idle the side is chosen from the valids; otherwise the registered direction rules.
    always_comb begin
        pick_ld = dir_r;
        if (state_r == S_IDLE) begin
            pick_ld = last_ld_r ? ~st_req_valid_i : ld_req_valid_i;
        end
    end

    assign grant_ok       = (state_r != S_DRAIN) && (count_r < CntW'(MaxOutstanding));
    assign sel_valid      = pick_ld ? ld_req_valid_i : st_req_valid_i;
    assign req_valid_o    = sel_valid & grant_ok;
    assign ld_req_ready_o = req_ready_i & grant_ok & pick_ld;
    assign st_req_ready_o = req_ready_i & grant_ok & ~pick_ld;

    always_comb begin
        req_o        = pick_ld ? ld_req_i : st_req_i;
        req_o.isLoad = pick_ld;
    end

    assign hs          = req_valid_o & req_ready_i;
    // A presented but unaccepted request pins the state so it is never dropped.
    assign hold        = req_valid_o & ~req_ready_i;
    assign dir_valid   = dir_r ? ld_req_valid_i : st_req_valid_i;
    assign other_valid = dir_r ? st_req_valid_i : ld_req_valid_i;

`ifdef RIVA_REQ_ARB_STARVE_EN
    localparam int unsigned WaitW = $clog2(StarveLimit + 1);
    logic [WaitW-1:0] ld_wait_r;
    logic [WaitW-1:0] st_wait_r;

    assign starve = (dir_r ? st_wait_r : ld_wait_r) >= WaitW'(StarveLimit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_wait_r <= '0;
            st_wait_r <= '0;
        end else begin
            if (hs && pick_ld) begin
                ld_wait_r <= '0;
            end else if (ld_req_valid_i && (ld_wait_r < WaitW'(StarveLimit))) begin
                ld_wait_r <= ld_wait_r + 1'b1;
            end
            if (hs && !pick_ld) begin
                st_wait_r <= '0;
            end else if (st_req_valid_i && (st_wait_r < WaitW'(StarveLimit))) begin
                st_wait_r <= st_wait_r + 1'b1;
            end
        end
    end
`else
    assign starve = 1'b0;
`endif

    // Done at zero is an error and leaves the count alone; inc and dec together cancel.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= '0;
            err_r   <= 1'b0;
        end else begin
            if (req_done_i && (count_r == '0)) begin
                err_r <= 1'b1;
            end
            if (hs && !(req_done_i && (count_r != '0))) begin
                count_r <= count_r + 1'b1;
            end else if (!hs && req_done_i && (count_r != '0)) begin
                count_r <= count_r - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= S_IDLE;
            dir_r     <= 1'b1;
            last_ld_r <= 1'b0;
        end else begin
            if (hs) begin
                last_ld_r <= pick_ld;
            end
            case (state_r)
                S_IDLE: begin
                    if (ld_req_valid_i || st_req_valid_i) begin
                        dir_r   <= pick_ld;
                        state_r <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (starve && !hold) begin
                        state_r <= S_DRAIN;
                    end else if (!dir_valid && other_valid) begin
                        state_r <= S_DRAIN;
                    end else if ((count_r == '0) && !ld_req_valid_i && !st_req_valid_i) begin
                        state_r <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (count_r == '0) begin
                        dir_r   <= ~dir_r;
                        state_r <= S_ACTIVE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign dir_o         = dir_r;
    assign outstanding_o = count_r;
    assign err_o         = err_r;
    assign state_o       = state_r;

endmodule

// File: tb/tb_vlsu_req_arbiter.sv
// Bench for vlsu_req_arbiter: protocol-abiding random requesters checked against a queue-based model.
// Expectations follow the RIVA_REQ_ARB_STARVE_EN setting of the build.
module tb_vlsu_req_arbiter;
    import vlsu_req_arbiter_pkg::*;

    localparam int MAX = 4;
    localparam int LIM = 8;
    localparam int CW  = $clog2(MAX + 1);
    localparam int W   = $bits(vlsu_req_default_t);
    typedef vlsu_req_default_t req_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ld_req_valid = 1'b0, st_req_valid = 1'b0;
    logic          ld_req_ready, st_req_ready;
    req_t          ld_req = '0, st_req = '0;
    logic          req_valid;
    logic          req_ready = 1'b0;
    req_t          req;
    logic          req_done = 1'b0;
    logic          dir;
    logic [CW-1:0] outstanding;
    logic          err;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    vlsu_req_arbiter #(
        .vlsu_req_t    (req_t),
        .MaxOutstanding(MAX),
        .StarveLimit   (LIM)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .ld_req_valid_i(ld_req_valid),
        .ld_req_ready_o(ld_req_ready),
        .ld_req_i      (ld_req),
        .st_req_valid_i(st_req_valid),
        .st_req_ready_o(st_req_ready),
        .st_req_i      (st_req),
        .req_valid_o   (req_valid),
        .req_ready_i   (req_ready),
        .req_o         (req),
        .req_done_i    (req_done),
        .dir_o         (dir),
        .outstanding_o (outstanding),
        .err_o         (err),
        .state_o       (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    // Model: owner mode (0 free, 1 owning, 2 handing over) and the in-flight requests.
    logic [W-1:0] exp_q[$];
    int  m_mode;
    bit  m_dir, m_last_ld, m_err;
    int  m_wait_ld, m_wait_st;

    // Requester agents: hold a request until it is accepted.
    bit   ld_pend, st_pend;
    req_t ld_pay, st_pay;
    int   st_grants;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.isLoad = 1'($urandom);
        r.addr   = $urandom;
        r.len    = 8'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_mode = 0; m_dir = 1'b1; m_last_ld = 1'b0; m_err = 1'b0;
        m_wait_ld = 0; m_wait_st = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ld_req_valid = 1'b0; st_req_valid = 1'b0; req_ready = 1'b0; req_done = 1'b0;
        ld_pend = 1'b0; st_pend = 1'b0;
        #1;
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_ld_ready", 64'(ld_req_ready), 64'd0);
        check("rst_st_ready", 64'(st_req_ready), 64'd0);
        check("rst_dir", 64'(dir), 64'd1);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input bit lv, input bit sv, input bit rr, input bit dn,
                        output bit lh, output bit sh);
        bit   pick, rv, may, hold, starve, dv, ov;
        int   cnt;
        req_t er;
        @(negedge clk);
        ld_req_valid = lv; st_req_valid = sv; req_ready = rr; req_done = dn;
        ld_req = ld_pay; st_req = st_pay;
        #1;
        cnt  = exp_q.size();
        may  = (m_mode != 2) && (cnt < MAX);
        if (m_mode == 0) pick = (lv && sv) ? !m_last_ld : lv;
        else             pick = m_dir;
        rv   = may && (pick ? lv : sv);
        er   = pick ? ld_pay : st_pay;
        er.isLoad = pick;
        check("req_valid", 64'(req_valid), 64'(rv));
        if (rv) check("req_o", 64'(req), 64'(er));
        if (m_mode != 0 || lv) check("ld_ready", 64'(ld_req_ready), 64'(rr && may && pick));
        if (m_mode != 0 || sv) check("st_ready", 64'(st_req_ready), 64'(rr && may && !pick));
        check("dir", 64'(dir), 64'(m_dir));
        check("outstanding", 64'(outstanding), 64'(cnt));
        check("err", 64'(err), 64'(m_err));
        lh   = rv && pick && rr;
        sh   = rv && !pick && rr;
        hold = rv && !rr;
`ifdef RIVA_REQ_ARB_STARVE_EN
        starve = (m_dir ? m_wait_st : m_wait_ld) >= LIM;
`else
        starve = 1'b0;
`endif
        @(posedge clk);
        if (dn) begin
            if (cnt == 0) m_err = 1'b1;
            else void'(exp_q.pop_front());
        end
        if (lh || sh) begin
            exp_q.push_back(W'(er));
            m_last_ld = pick;
        end
        if (lh) m_wait_ld = 0; else if (lv && m_wait_ld < LIM) m_wait_ld++;
        if (sh) m_wait_st = 0; else if (sv && m_wait_st < LIM) m_wait_st++;
        dv = m_dir ? lv : sv;
        ov = m_dir ? sv : lv;
        case (m_mode)
            0: if (lv || sv) begin m_dir = pick; m_mode = 1; end
            1: begin
                if (starve && !hold)              m_mode = 2;
                else if (!dv && ov)               m_mode = 2;
                else if (cnt == 0 && !lv && !sv)  m_mode = 0;
            end
            default: if (cnt == 0) begin m_dir = !m_dir; m_mode = 1; end
        endcase
    endtask

    // Percent probabilities: new load, new store, fragmenter ready, done pulse (only when in flight).
    task automatic flow(input int n, input int pl, input int ps, input int pr, input int pd);
        bit rr, dn, lh, sh;
        for (int i = 0; i < n; i++) begin
            if (!ld_pend && int'($urandom_range(99)) < pl) begin ld_pend = 1'b1; ld_pay = rand_req(); end
            if (!st_pend && int'($urandom_range(99)) < ps) begin st_pend = 1'b1; st_pay = rand_req(); end
            rr = int'($urandom_range(99)) < pr;
            dn = (exp_q.size() > 0) && (int'($urandom_range(99)) < pd);
            step(ld_pend, st_pend, rr, dn, lh, sh);
            if (lh) ld_pend = 1'b0;
            if (sh) begin st_pend = 1'b0; st_grants++; end
        end
    endtask

    initial begin
        bit lh, sh;
        ld_pay = '0; st_pay = '0; st_grants = 0;
        model_reset();
        do_reset();

        // Single load carrying isLoad=0 is forwarded the same cycle as a load.
        ld_pay = rand_req(); ld_pay.isLoad = 1'b0; ld_pend = 1'b1;
        step(1'b1, 1'b0, 1'b1, 1'b0, lh, sh);
        if (lh) ld_pend = 1'b0;
        check("first_load_hs", 64'(lh), 64'd1);

        // Fill to the outstanding limit, then one done frees a slot.
        flow(6, 100, 0, 100, 0);
        check("stall_at_max", 64'(outstanding), 64'(MAX));
        flow(3, 100, 0, 100, 100);
        flow(12, 0, 0, 100, 100);

        // Two loads in flight, then a store waits for the drain.
        flow(2, 100, 0, 100, 0);
        flow(4, 0, 100, 100, 0);
        check("store_blocked", 64'(st_grants), 64'd0);
        flow(8, 0, 100, 100, 60);
        flow(12, 0, 0, 100, 100);

        // Both valid in idle alternate on the last granted side.
        flow(4, 100, 100, 100, 100);
        flow(12, 0, 0, 100, 100);
        flow(4, 100, 100, 100, 100);
        flow(12, 0, 0, 100, 100);

        // Continuous loads with a waiting store.
        flow(3, 100, 0, 100, 50);
        st_grants = 0;
        flow(40, 100, 100, 100, 50);
`ifdef RIVA_REQ_ARB_STARVE_EN
        check("starve_store_granted", 64'(st_grants > 0), 64'd1);
`else
        check("no_starve_store_blocked", 64'(st_grants), 64'd0);
`endif
        flow(20, 0, 0, 100, 100);

        // Done pulse with nothing in flight.
        step(1'b0, 1'b0, 1'b1, 1'b1, lh, sh);
        flow(3, 0, 0, 100, 0);
        check("err_sticky", 64'(err), 64'd1);
        check("err_count_zero", 64'(outstanding), 64'd0);

        flow(400, 30, 30, 70, 40);
        do_reset();
        flow(300, 40, 40, 60, 45);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
